// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache in front of instruction fetch.
// Combinational lookup; misses refill a whole line over a req/ack word handshake.
module instruction_cache #(
  parameter int ADDR_W     = 30,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic [31:0]       ins,
  output logic              hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(LINE_WORDS - 1);
  localparam logic [OFF_W:0] CNT_ONE  = (OFF_W+1)'(1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [OFF_W:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]      fill_base_q, fill_base_d;
  logic [IDX_W-1:0]       fill_idx_q, fill_idx_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   data_we, tag_we;

  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]       pc_off;
  logic [IDX_W-1:0]       pc_idx;
  logic [TAG_W-1:0]       pc_tag;

  assign pc_off = pc_addr[OFF_W-1:0];
  assign pc_idx = pc_addr[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag = pc_addr[ADDR_W-1:OFF_W+IDX_W];

  assign hit      = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign ins      = hit ? data_q[pc_idx][pc_off] : 32'h0000_0000;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      fill_base_q <= '0;
      fill_idx_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      fill_base_q <= fill_base_d;
      fill_idx_q  <= fill_idx_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Arrays carry no reset; the valid bits alone decide residency.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_q[fill_idx_q][cnt_q[OFF_W-1:0]] <= mem_rdata;
    if (!rst && tag_we)  tag_q[fill_idx_q] <= fill_base_q[ADDR_W-1 -: TAG_W];
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    fill_base_d = fill_base_q;
    fill_idx_d  = fill_idx_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (!hit) begin
          // Invalidate the target up front so a half-written line never hits.
          valid_d[pc_idx] = 1'b0;
          fill_base_d     = {pc_tag, pc_idx, {OFF_W{1'b0}}};
          fill_idx_d      = pc_idx;
          cnt_d           = '0;
          mem_req_d       = 1'b1;
          mem_addr_d      = {pc_tag, pc_idx, {OFF_W{1'b0}}};
          state_d         = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          valid_d   = '0;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (mem_ack) begin
          data_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            tag_we              = 1'b1;
            valid_d[fill_idx_q] = 1'b1;
            mem_req_d           = 1'b0;
            cnt_d               = '0;
            state_d             = IDLE;
          end else begin
            cnt_d      = cnt_q + CNT_ONE;
            mem_addr_d = fill_base_q + ADDR_W'(cnt_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
